// File: rtl/uart_rx_deser_if.sv
// Byte stream from the UART receiver to the probe command decoder.
// The master presents the head byte; the slave accepts it with rx_ready.
interface uart_rx_deser_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronizes rxd, recovers frames by mid-bit sampling
// and queues good bytes in a small FIFO. Framing and overrun errors are one-cycle pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a low level on rxs
// ST_START | half-bit wait, then confirm the start bit is still low
// ST_DATA  | sample 8 data bits LSB first, one per bit time
// ST_STOP  | one bit time, then sample the stop bit
// ST_BREAK | stop bit was low; wait for the line to return high
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            m_aresetn,
  input  logic            rxd,
  uart_rx_deser_if.master rx_if,
  output logic            frame_err,
  output logic            overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

  logic          rxd_meta_q, rxd_meta_d, rxs_q, rxs_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic          push, pop, wr_en, empty, full;

  always_comb begin
    rxd_meta_d  = rxd;
    rxs_d       = rxd_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_TC) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rxs_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_TC) begin
          cnt_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = !empty && rx_if.rx_ready;
    wr_en     = push && (!full || pop);
    overrun_d = push && full && !pop;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = shreg_q;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      rxd_meta_q  <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '{default: '0};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd_meta_d;
      rxs_q       <= rxs_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_valid = !empty;
  assign rx_if.rx_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: frame-level model of the FIFO contents and
// error pulses, compared against the DUT every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_uart_rx_deser;
  localparam int N     = 16;
  localparam int HALF  = N / 2;
  localparam int DEPTH = 4;
  // rxd fall to stop-sample edge: 2 sync flops, 1 idle detect, half bit, 8 data bits + stop bit.
  localparam int PUSH_LAT = 2 + 1 + HALF + 9 * N;

  logic clk = 1'b0;
  logic m_aresetn = 1'b0;
  logic rxd = 1'b1;
  logic frame_err, overrun;
  logic ready_mode = 1'b0, ready_man = 1'b0, ready_reg = 1'b0;

  uart_rx_deser_if rif();

  uart_rx_deser #(.CLKS_PER_BIT(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .m_aresetn (m_aresetn),
    .rxd       (rxd),
    .rx_if     (rif),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  assign rif.rx_ready = ready_mode ? ready_reg : ready_man;

  // Consumer that registers rx_ready from rx_valid, like the probe.
  initial begin : ready_follow
    logic v;
    forever begin
      @(negedge clk);
      v = rif.rx_valid;
      @(posedge clk);
      #1 ready_reg = v;
    end
  end

  typedef struct {
    int         edge_n;
    bit         is_err;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  logic [7:0] got[$];
  int  cyc = 0;
  bit  exp_ferr = 1'b0, exp_ovr = 1'b0;
  int  checks = 0, failures = 0;
  int  ovr_cnt = 0, ferr_cnt = 0;
  int  last_c0 = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Frame-level model: a byte queue bounded at DEPTH, fed by scheduled frame events.
  always @(posedge clk) begin
    bit pop;
    cyc++;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (!m_aresetn) begin
      mq.delete();
      evq.delete();
    end else begin
      pop = (mq.size() > 0) && (rif.rx_ready === 1'b1);
      if (pop) void'(mq.pop_front());
      if (evq.size() > 0 && evq[0].edge_n == cyc) begin
        if (evq[0].is_err)          exp_ferr = 1'b1;
        else if (mq.size() == DEPTH) exp_ovr = 1'b1;
        else                        mq.push_back(evq[0].b);
        void'(evq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    chk("rx_valid", rif.rx_valid, mq.size() > 0);
    chk("frame_err", frame_err, exp_ferr);
    chk("overrun", overrun, exp_ovr);
    if (mq.size() > 0) chk("rx_data", rif.rx_data, mq[0]);
    if (overrun === 1'b1)   ovr_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_val = 1'b1, input int stop_bits = 1);
    ev_t e;
    last_c0  = cyc;
    e.edge_n = cyc + PUSH_LAT;
    e.is_err = !stop_val;
    e.b      = b;
    evq.push_back(e);
    rxd = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(N);
    end
    rxd = stop_val;
    tick(stop_bits * N);
    rxd = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    got.delete();
    ready_man = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rif.rx_valid === 1'b1) got.push_back(rif.rx_data);
      @(posedge clk);
      #1;
    end
    ready_man = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_valid"}, rif.rx_valid, 8'h00);
    chk({tag, "_rx_data"}, rif.rx_data, 8'h00);
    chk({tag, "_frame_err"}, frame_err, 8'h00);
    chk({tag, "_overrun"}, overrun, 8'h00);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int o0, f0;
    tick(3);
    check_reset_outputs("reset");
    m_aresetn = 1'b1;
    tick(5);

    // Single frame with the registered-ready consumer.
    ready_mode = 1'b1;
    fork
      send_frame(8'hA5);
      begin : mon
        int lat, hi;
        logic [7:0] d;
        lat = -1;
        hi  = 0;
        d   = 8'h00;
        for (int i = 0; i < PUSH_LAT + 40; i++) begin
          @(negedge clk);
          if (rif.rx_valid === 1'b1) begin
            hi++;
            if (lat < 0) begin
              lat = cyc - last_c0;
              d   = rif.rx_data;
            end
          end
        end
        chk_int("single_latency_in_window", int'(lat >= 154 && lat <= 156), 1);
        chk_int("single_latency", lat, 155);
        chk("single_byte", d, 8'hA5);
        chk_int("single_valid_cycles", hi, 2);
      end
    join
    ready_mode = 1'b0;
    tick(5);

    // Back-to-back burst held, then drained in order.
    for (int i = 1; i <= 4; i++) send_frame(8'(i));
    tick(20);
    drain(12);
    chk_int("burst_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("burst_byte", got[i], 8'(i + 1));
    chk("burst_valid_after", rif.rx_valid, 8'h00);

    // Overrun on the fifth frame, then a push that coincides with a pop.
    o0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i));
    tick(20);
    chk_int("overrun_pulses", ovr_cnt - o0, 1);
    o0 = ovr_cnt;
    fork
      send_frame(8'h06);
      begin
        tick(PUSH_LAT - 1);
        ready_man = 1'b1;
        tick(1);
        ready_man = 1'b0;
      end
    join
    tick(10);
    chk_int("overrun_on_push_pop", ovr_cnt - o0, 0);
    drain(12);
    chk_int("overrun_drain_count", got.size(), 4);
    chk("overrun_byte0", got[0], 8'h02);
    chk("overrun_byte1", got[1], 8'h03);
    chk("overrun_byte2", got[2], 8'h04);
    chk("overrun_last", got[3], 8'h06);

    // Framing error with a long low stop, then a clean frame.
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 3);
    tick(10);
    chk_int("frame_err_pulses", ferr_cnt - f0, 1);
    chk("frame_err_no_push", rif.rx_valid, 8'h00);
    send_frame(8'h55);
    tick(10);
    drain(6);
    chk_int("after_ferr_count", got.size(), 1);
    chk("after_ferr_byte", got[0], 8'h55);

    // Glitch shorter than half a bit.
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    rxd = 1'b0;
    tick(N / 4);
    rxd = 1'b1;
    tick(3 * N);
    chk("glitch_no_push", rif.rx_valid, 8'h00);
    chk_int("glitch_no_ferr", ferr_cnt - f0, 0);
    chk_int("glitch_no_ovr", ovr_cnt - o0, 0);

    // Reset in the middle of a 0xFF frame with a byte still queued.
    send_frame(8'h5A);
    tick(5);
    chk("queued_before_reset", rif.rx_data, 8'h5A);
    rxd = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b1;
      tick(N);
    end
    tick(N / 2);
    m_aresetn = 1'b0;
    mq.delete();
    evq.delete();
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    tick(3);
    check_reset_outputs("midreset");
    m_aresetn = 1'b1;
    tick(6 * N);
    send_frame(8'h81);
    tick(10);
    drain(6);
    chk_int("post_reset_count", got.size(), 1);
    chk("post_reset_byte", got[0], 8'h81);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
